// File: rtl/fifo_wr_arb_rr.sv
// Packet-atomic round-robin arbiter for the write port of a shared single-clock FIFO.
// A grant is held from the first beat to the last beat of a packet. A packet that runs too long is cut off and flagged.
module fifo_wr_arb_rr #(
    parameter  int CHN_NUM = 4,
    parameter  int DATA_WD = 32,
    parameter  int BST_MAX = 8,
    localparam int CHN_WD  = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1,
    localparam int BST_WD  = $clog2(BST_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHN_NUM-1:0]         req_val_i,
    input  logic [CHN_NUM*DATA_WD-1:0] req_dat_i,
    input  logic [CHN_NUM-1:0]         req_lst_i,
    output logic [CHN_NUM-1:0]         req_rdy_o,
    output logic                       fifo_wr_val_o,
    output logic [DATA_WD-1:0]         fifo_wr_dat_o,
    input  logic                       fifo_wr_ful_i,
    output logic                       gnt_bsy_o,
    output logic [CHN_WD-1:0]          gnt_idx_o,
    output logic [15:0]                pkt_cnt_o,
    output logic                       err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CHN_WD-1:0]   ptr_q, ptr_d;
    logic [CHN_WD-1:0]   idx_q, idx_d;
    logic [BST_WD-1:0]   cnt_q, cnt_d;
    logic [15:0]         pkt_q, pkt_d;
    logic                err_q, err_d;

    logic [CHN_WD-1:0]   cand;
    logic [CHN_WD-1:0]   pick_idx;
    logic                pick_ok;
    logic [CHN_WD-1:0]   sel;
    logic                sel_val;
    logic                sel_lst;
    logic                xfer;
    logic [CHN_WD-1:0]   nxt_ptr;

    // Scan downwards from the farthest candidate so that the last hit is the first one at or after ptr.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        pick_ok  = 1'b0;
        for (int k = CHN_NUM - 1; k >= 0; k--) begin
            cand = CHN_WD'((int'(ptr_q) + k) % CHN_NUM);
            if (req_val_i[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign sel     = (state_q == BUSY) ? idx_q : pick_idx;
    assign sel_val = (state_q == BUSY) ? req_val_i[idx_q] : pick_ok;
    assign sel_lst = req_lst_i[sel];
    assign xfer    = sel_val && !fifo_wr_ful_i;
    assign nxt_ptr = (sel == CHN_WD'(CHN_NUM - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        req_rdy_o     = '0;
        fifo_wr_dat_o = '0;
        for (int k = 0; k < CHN_NUM; k++) begin
            if (xfer && (sel == CHN_WD'(k))) begin
                req_rdy_o[k]  = 1'b1;
                fifo_wr_dat_o = req_dat_i[k*DATA_WD +: DATA_WD];
            end
        end
    end

    assign fifo_wr_val_o = xfer;

    // NOTE: every next-state value takes its current value first, so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    idx_d = sel;
                    if (sel_lst) begin
                        ptr_d = nxt_ptr;
                        pkt_d = pkt_q + 16'd1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = BST_WD'(1);
                    end
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (sel_lst || ((cnt_q + 1'b1) == BST_WD'(BST_MAX))) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                        pkt_d   = pkt_q + 16'd1;
                        cnt_d   = '0;
                        if (!sel_lst) err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so that every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    assign gnt_bsy_o = (state_q == BUSY);
    assign gnt_idx_o = idx_q;
    assign pkt_cnt_o = pkt_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_fifo_wr_arb_rr.sv
// Bench for fifo_wr_arb_rr: directed scenarios plus random traffic.
// Each cycle is compared against a packet-level reference model.
module tb_fifo_wr_arb_rr;

    localparam int N   = 4;
    localparam int BST = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_val;
    logic [N-1:0]   req_lst;
    logic [31:0]    dat_a [N];
    logic [N*32-1:0] req_dat;
    logic [N-1:0]   rdy;
    logic           wv;
    logic [31:0]    wd;
    logic           ful;
    logic           bsy;
    logic [1:0]     idx;
    logic [15:0]    pkt;
    logic           err;

    int checks = 0;
    int errors = 0;

    // Reference model state: packet lock, rotation start, beats in packet, counters.
    bit          m_busy;
    int          m_lock, m_ptr, m_cnt, m_gidx;
    logic [15:0] m_pkt;
    bit          m_err;

    // Values seen on the comb outputs during the most recent cycle.
    logic [N-1:0] rdy_s;
    logic         wv_s;
    logic [31:0]  wd_s;

    int           phase [N];
    logic [31:0]  wq [$];

    always_comb req_dat = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

    fifo_wr_arb_rr #(.CHN_NUM(N), .DATA_WD(32), .BST_MAX(BST)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val_i     (req_val),
        .req_dat_i     (req_dat),
        .req_lst_i     (req_lst),
        .req_rdy_o     (rdy),
        .fifo_wr_val_o (wv),
        .fifo_wr_dat_o (wd),
        .fifo_wr_ful_i (ful),
        .gnt_bsy_o     (bsy),
        .gnt_idx_o     (idx),
        .pkt_cnt_o     (pkt),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input bit v, input bit l, input logic [31:0] d);
        req_val[2'(k)] = v;
        req_lst[2'(k)] = l;
        dat_a[2'(k)]   = d;
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) set_ch(k, 1'b0, 1'b0, 32'h0);
    endtask

    // One clock: compare comb outputs at the falling edge, advance the model at the rising edge, then compare registers.
    task automatic cycle();
        int           sel;
        bit           has;
        bit           x;
        bit           lst;
        logic [N-1:0] e_rdy;
        @(negedge clk);
        has = 1'b0;
        sel = 0;
        if (m_busy) begin
            sel = m_lock;
            has = req_val[2'(m_lock)];
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!has && req_val[2'((m_ptr + i) % N)]) begin
                    has = 1'b1;
                    sel = (m_ptr + i) % N;
                end
            end
        end
        x     = has && !ful;
        lst   = req_lst[2'(sel)];
        e_rdy = x ? 4'(1 << sel) : 4'b0;
        chk("req_rdy", 32'(rdy), 32'(e_rdy));
        chk("wr_val", 32'(wv), 32'(x));
        if (x) chk("wr_dat", wd, dat_a[2'(sel)]);
        rdy_s = rdy;
        wv_s  = wv;
        wd_s  = wd;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_lock = 0; m_ptr = 0; m_cnt = 0; m_gidx = 0; m_pkt = 16'd0; m_err = 0;
        end else if (x) begin
            if (!m_busy) begin
                m_gidx = sel;
                if (lst) begin
                    m_pkt = m_pkt + 16'd1;
                    m_ptr = (sel + 1) % N;
                end else begin
                    m_busy = 1; m_lock = sel; m_cnt = 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (lst || m_cnt == BST) begin
                    if (!lst) m_err = 1;
                    m_busy = 0;
                    m_cnt  = 0;
                    m_ptr  = (m_lock + 1) % N;
                    m_pkt  = m_pkt + 16'd1;
                end
            end
        end
        #1;
        chk("gnt_bsy", 32'(bsy), 32'(m_busy));
        chk("gnt_idx", 32'(idx), 32'(m_gidx));
        chk("pkt_cnt", 32'(pkt), 32'(m_pkt));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int wrs;
        rst = 1'b1;
        ful = 1'b0;
        req_val = '0;
        req_lst = '0;
        for (int k = 0; k < N; k++) dat_a[k] = 32'h0;
        m_busy = 0; m_lock = 0; m_ptr = 0; m_cnt = 0; m_gidx = 0; m_pkt = 16'd0; m_err = 0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_bsy", 32'(bsy), 32'h0);
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_pkt", 32'(pkt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Single-beat packet on ch1, then the pointer has moved to 2
        set_ch(1, 1, 1, 32'hA1);
        cycle();
        chk("t1_rdy", 32'(rdy_s), 32'h2);
        chk("t1_dat", wd_s, 32'hA1);
        chk("t1_pkt", 32'(pkt), 32'h1);
        chk("t1_idx", 32'(idx), 32'h1);
        clear_all();
        set_ch(0, 1, 1, 32'hB0);
        set_ch(3, 1, 1, 32'hB3);
        cycle();
        chk("t1_ptr2", 32'(rdy_s), 32'h8);
        clear_all();

        // All channels stream two-beat packets; order must be 0,0,1,1,2,2,3,3
        do_reset();
        for (int k = 0; k < N; k++) phase[k] = 0;
        wq.delete();
        n = 0;
        while (wq.size() < 8 && n < 40) begin
            for (int k = 0; k < N; k++) set_ch(k, 1, phase[k][0], 32'hC0 + 32'(k));
            cycle();
            for (int k = 0; k < N; k++) if (rdy_s[2'(k)]) phase[k] = 1 - phase[k];
            if (wv_s) wq.push_back(wd_s);
            n++;
        end
        chk("t2_beats", 32'(wq.size()), 32'd8);
        for (int i = 0; i < 8 && i < wq.size(); i++) chk("t2_order", wq[i], 32'hC0 + 32'(i / 2));
        chk("t2_pkt", 32'(pkt), 32'd4);
        clear_all();

        // ch2 locked, FIFO full for three cycles at beat 2
        do_reset();
        set_ch(2, 1, 0, 32'h21);
        cycle();
        set_ch(2, 1, 1, 32'h22);
        set_ch(0, 1, 1, 32'h01);
        ful = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_val", 32'(wv_s), 32'h0);
            chk("t3_rdy", 32'(rdy_s), 32'h0);
            chk("t3_bsy", 32'(bsy), 32'h1);
            chk("t3_idx", 32'(idx), 32'h2);
        end
        ful = 1'b0;
        cycle();
        chk("t3_dat", wd_s, 32'h22);
        chk("t3_rdy2", 32'(rdy_s), 32'h4);
        chk("t3_rel", 32'(bsy), 32'h0);
        clear_all();

        // ch0 locked and idle while ch1 requests
        do_reset();
        set_ch(0, 1, 0, 32'h10);
        cycle();
        set_ch(0, 0, 0, 32'h11);
        set_ch(1, 1, 1, 32'h20);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_hold", 32'(rdy_s), 32'h0);
        end
        set_ch(0, 1, 1, 32'h12);
        cycle();
        chk("t4_lst", 32'(rdy_s), 32'h1);
        set_ch(0, 0, 0, 32'h0);
        cycle();
        chk("t4_ch1", 32'(rdy_s), 32'h2);
        clear_all();

        // ch3 overruns the burst limit
        do_reset();
        set_ch(3, 1, 0, 32'h33);
        wrs = 0;
        for (int i = 0; i < BST; i++) begin
            cycle();
            if (wv_s) wrs++;
        end
        chk("t5_beats", 32'(wrs), 32'(BST));
        chk("t5_bsy", 32'(bsy), 32'h0);
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_pkt", 32'(pkt), 32'h1);
        set_ch(0, 1, 1, 32'h05);
        cycle();
        chk("t5_next", 32'(rdy_s), 32'h1);
        clear_all();

        // Reset while ch1 is mid-packet
        set_ch(1, 1, 0, 32'h61);
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_busy", 32'(bsy), 32'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_bsy", 32'(bsy), 32'h0);
        chk("t6_idx", 32'(idx), 32'h0);
        chk("t6_pkt", 32'(pkt), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        set_ch(0, 1, 1, 32'h70);
        set_ch(1, 1, 1, 32'h71);
        cycle();
        chk("t6_ptr0", 32'(rdy_s), 32'h1);
        clear_all();

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < N; k++)
                set_ch(k, 1'($urandom_range(0, 1)), ($urandom % 6) == 0, $urandom);
            ful = ($urandom % 5) == 0;
            rst = ($urandom % 97) == 0;
            cycle();
        end
        rst = 1'b0;
        ful = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
